// File: rtl/ppi_commutator.sv
// ppi_commutator: output commutator of the polyphase interpolator.
// Captures one vector of gp_interpolation_factor phase results, then
// serializes it one phase per enabled clock with scaling and saturation.
// Optional build macro PPI_COMMUTATOR_ROUND_EN selects round half-up before
// the shift; without it the shift truncates.
module ppi_commutator #(
    parameter int gp_data_width           = 20,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_shift                = 2,
    parameter int gp_odata_width          = 16,
    localparam int c_cnt_width = (gp_interpolation_factor > 1) ? $clog2(gp_interpolation_factor) : 1
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst_an,
    input  logic                                                i_ena,
    input  logic                                                i_valid,
    input  logic [gp_interpolation_factor*gp_data_width-1:0]    i_data,
    input  logic                                                i_clr,
    output logic signed [gp_odata_width-1:0]                    o_data,
    output logic                                                o_valid,
    output logic [c_cnt_width-1:0]                              o_phase,
    output logic                                                o_overrun
);

    localparam int W  = gp_data_width;
    localparam int L  = gp_interpolation_factor;
    localparam int OW = gp_odata_width;

    localparam logic [c_cnt_width-1:0] c_last = c_cnt_width'(L - 1);
    // Saturation bounds expressed at the widened scaled width.
    localparam logic signed [W:0] c_max = {{(W + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [W:0] c_min = {{(W + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};
`ifdef PPI_COMMUTATOR_ROUND_EN
    localparam logic signed [W:0] c_half = (W + 1)'((gp_shift > 0) ? (1 << (gp_shift - 1)) : 0);
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [c_cnt_width-1:0]  cnt, cnt_nxt;
    logic                    load, emit, ovr_set;

    logic signed [W-1:0]     hold_p0 [L];
    logic signed [OW-1:0]    data_p1;
    logic [c_cnt_width-1:0]  phase_p1;
    logic                    vld_p1;
    logic                    overrun;

    // Widen by one bit so the rounding carry cannot wrap, then shift.
    function automatic logic signed [W:0] scale_fn(input logic signed [W-1:0] x);
        logic signed [W:0] ext;
        ext = {x[W-1], x};
`ifdef PPI_COMMUTATOR_ROUND_EN
        ext = ext + c_half;
`endif
        return ext >>> gp_shift;
    endfunction

    // Clamp the scaled value into the signed output range.
    function automatic logic signed [OW-1:0] sat_fn(input logic signed [W:0] v);
        logic signed [W:0] r;
        if (v > c_max)      r = c_max;
        else if (v < c_min) r = c_min;
        else                r = v;
        return r[OW-1:0];
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (i_ena) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state decode: capture, advance, seamless reload or overrun.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        emit      = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                emit = 1'b1;
                if (cnt == c_last) begin
                    cnt_nxt = '0;
                    if (i_valid) load = 1'b1;
                    else         state_nxt = IDLE;
                end else if (i_valid) begin
                    ovr_set = 1'b1;
                    load    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: vector capture into the phase holding registers.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int k = 0; k < L; k++) hold_p0[k] <= '0;
        end else if (i_ena && load) begin
            for (int k = 0; k < L; k++) hold_p0[k] <= i_data[k*W +: W];
        end
    end

    // Stage p1: scaled, saturated phase out with its index and valid flag.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            data_p1  <= '0;
            phase_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (i_ena) begin
            vld_p1 <= emit;
            if (emit) begin
                data_p1  <= sat_fn(scale_fn(hold_p0[cnt]));
                phase_p1 <= cnt;
            end
        end
    end

    // Sticky overrun: a new overrun wins over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an)         overrun <= 1'b0;
        else if (i_ena) begin
            if (ovr_set)       overrun <= 1'b1;
            else if (i_clr)    overrun <= 1'b0;
        end
    end

    assign o_data    = data_p1;
    assign o_phase   = phase_p1;
    assign o_valid   = vld_p1 & i_ena;
    assign o_overrun = overrun;

endmodule

// File: tb/tb_ppi_commutator.sv
// Directed self-checking bench for ppi_commutator (L=4, W=20, shift=2, OW=16).
module tb_ppi_commutator;

    localparam int W = 20;
    localparam int L = 4;
    localparam int OW = 16;
    localparam int CW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_an = 1'b0;
    logic              i_ena = 1'b1;
    logic              i_valid = 1'b0;
    logic [L*W-1:0]    i_data = '0;
    logic              i_clr = 1'b0;
    logic [OW-1:0]     o_data;
    logic              o_valid;
    logic [CW-1:0]     o_phase;
    logic              o_overrun;

    int tests = 0;
    int fails = 0;

    ppi_commutator #(
        .gp_data_width(W), .gp_interpolation_factor(L),
        .gp_shift(2), .gp_odata_width(OW)
    ) dut (
        .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_valid(i_valid),
        .i_data(i_data), .i_clr(i_clr), .o_data(o_data), .o_valid(o_valid),
        .o_phase(o_phase), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_vec(input logic [W-1:0] p0, input logic [W-1:0] p1,
                           input logic [W-1:0] p2, input logic [W-1:0] p3);
        i_data = {p3, p2, p1, p0};
    endtask

    // Capture edge: one-cycle i_valid strobe.
    task automatic strobe();
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_an = 1'b0;
        repeat (3) tick();
        tests++;
        if (o_data !== 16'h0000 || o_valid !== 1'b0 || o_phase !== 2'd0 || o_overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset: data=%h valid=%b phase=%0d ovr=%b, want 0 0 0 0", o_data, o_valid, o_phase, o_overrun);
        end
        i_rst_an = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_burst();
        logic [OW-1:0] exp_d [4];
        exp_d[0] = 16'd1; exp_d[1] = 16'd2; exp_d[2] = 16'd3; exp_d[3] = 16'd4;
        set_vec(20'h00004, 20'h00008, 20'h0000C, 20'h00010);
        strobe();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (o_valid !== 1'b1 || o_data !== exp_d[k] || o_phase !== CW'(k)) begin
                fails++;
                $display("FAIL single_burst k=%0d: valid=%b data=%h phase=%0d, want 1 %h %0d", k, o_valid, o_data, o_phase, exp_d[k], k);
            end
        end
        tick();
        tests++;
        if (o_valid !== 1'b0 || o_data !== 16'd4) begin
            fails++;
            $display("FAIL single_burst_end: valid=%b data=%h, want 0 0004", o_valid, o_data);
        end
    endtask

    task automatic test_saturation();
        set_vec(20'h7FFFF, 20'h80000, 20'h00000, 20'h00000);
        strobe();
        tick();
        tests++;
        if (o_data !== 16'h7FFF) begin
            fails++;
            $display("FAIL sat_pos: data=%h, want 7fff", o_data);
        end
        tick();
        tests++;
        if (o_data !== 16'h8000) begin
            fails++;
            $display("FAIL sat_neg: data=%h, want 8000", o_data);
        end
        repeat (3) tick();
    endtask

    task automatic test_rounding();
        logic [OW-1:0] e0, e1;
`ifdef PPI_COMMUTATOR_ROUND_EN
        e0 = 16'd2; e1 = 16'hFFFF;
`else
        e0 = 16'd1; e1 = 16'hFFFE;
`endif
        set_vec(20'd6, 20'hFFFFA, 20'd0, 20'd0);
        strobe();
        tick();
        tests++;
        if (o_data !== e0) begin
            fails++;
            $display("FAIL round_pos: data=%h, want %h", o_data, e0);
        end
        tick();
        tests++;
        if (o_data !== e1) begin
            fails++;
            $display("FAIL round_neg: data=%h, want %h", o_data, e1);
        end
        repeat (3) tick();
    endtask

    // Vector v phase k holds (v*4+k+1)*4, so output is v*4+k+1.
    task automatic test_back_to_back();
        int bad;
        logic [OW-1:0] e;
        bad = 0;
        for (int c = 0; c < 14; c++) begin
            i_valid = (c % 4 == 0) && (c < 12);
            if (i_valid)
                set_vec(20'((c/4*4+1)*4), 20'((c/4*4+2)*4), 20'((c/4*4+3)*4), 20'((c/4*4+4)*4));
            tick();
            if (c >= 1 && c <= 12) begin
                e = 16'(c);
                tests++;
                if (o_valid !== 1'b1 || o_data !== e || o_phase !== CW'((c - 1) % 4)) begin
                    fails++;
                    $display("FAIL back_to_back c=%0d: valid=%b data=%h phase=%0d, want 1 %h %0d", c, o_valid, o_data, o_phase, e, (c - 1) % 4);
                end
            end
        end
        i_valid = 1'b0;
        tests++;
        if (o_valid !== 1'b0 || o_overrun !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_end: valid=%b ovr=%b, want 0 0", o_valid, o_overrun);
        end
    endtask

    task automatic test_overrun();
        set_vec(20'h00040, 20'h00044, 20'h00048, 20'h0004C);
        strobe();
        tick();
        set_vec(20'h00080, 20'h00084, 20'h00088, 20'h0008C);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tests++;
        if (o_overrun !== 1'b1 || o_phase !== 2'd1 || o_data !== 16'h0011) begin
            fails++;
            $display("FAIL overrun_set: ovr=%b phase=%0d data=%h, want 1 1 0011", o_overrun, o_phase, o_data);
        end
        tick();
        tests++;
        if (o_phase !== 2'd0 || o_data !== 16'h0020 || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL overrun_restart: phase=%0d data=%h valid=%b, want 0 0020 1", o_phase, o_data, o_valid);
        end
        repeat (4) tick();
        tests++;
        if (o_overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: ovr=%b, want 1", o_overrun);
        end
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        tests++;
        if (o_overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: ovr=%b, want 0", o_overrun);
        end
    endtask

    task automatic test_enable_freeze();
        set_vec(20'h00014, 20'h00018, 20'h0001C, 20'h00020);
        strobe();
        tick();
        tick();
        i_ena = 1'b0;
        i_valid = 1'b1;
        set_vec(20'h00100, 20'h00100, 20'h00100, 20'h00100);
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (o_valid !== 1'b0 || o_data !== 16'd6 || o_phase !== 2'd1) begin
                fails++;
                $display("FAIL freeze c=%0d: valid=%b data=%h phase=%0d, want 0 0006 1", c, o_valid, o_data, o_phase);
            end
        end
        i_valid = 1'b0;
        i_ena = 1'b1;
        tick();
        tests++;
        if (o_valid !== 1'b1 || o_data !== 16'd7 || o_phase !== 2'd2) begin
            fails++;
            $display("FAIL resume_p2: valid=%b data=%h phase=%0d, want 1 0007 2", o_valid, o_data, o_phase);
        end
        tick();
        tests++;
        if (o_valid !== 1'b1 || o_data !== 16'd8 || o_phase !== 2'd3) begin
            fails++;
            $display("FAIL resume_p3: valid=%b data=%h phase=%0d, want 1 0008 3", o_valid, o_data, o_phase);
        end
        tick();
        tests++;
        if (o_valid !== 1'b0 || o_overrun !== 1'b0) begin
            fails++;
            $display("FAIL resume_end: valid=%b ovr=%b, want 0 0", o_valid, o_overrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        set_vec(20'h00024, 20'h00028, 20'h0002C, 20'h00030);
        strobe();
        repeat (3) tick();
        #2;
        i_rst_an = 1'b0;
        #1;
        tests++;
        if (o_data !== 16'h0000 || o_valid !== 1'b0 || o_phase !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid: data=%h valid=%b phase=%0d, want 0000 0 0", o_data, o_valid, o_phase);
        end
        #1;
        i_rst_an = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_discard: valid cycles=%0d, want 0", seen);
        end
        set_vec(20'h00034, 20'h0, 20'h0, 20'h0);
        strobe();
        tick();
        tests++;
        if (o_valid !== 1'b1 || o_data !== 16'd13 || o_phase !== 2'd0) begin
            fails++;
            $display("FAIL reset_recover: valid=%b data=%h phase=%0d, want 1 000d 0", o_valid, o_data, o_phase);
        end
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_overrun();
        test_enable_freeze();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ppi_commutator.md
Name: ppi_commutator

Overview:
- Output commutator for the polyphase interpolator datapath; sits directly downstream of the polyphase multiply-add core.
- Captures one low-rate vector of gp_interpolation_factor phase results, then serializes it at the high rate, one phase per enabled clock.
- Each phase is scaled, optionally rounded, and saturated to the output width.
- Reports an overrun when a new vector arrives before the previous one has fully drained.

Parameters:
- gp_data_width, 20, bit-width of each phase result (signed).
- gp_interpolation_factor, 4, number of phases per input vector (L), >=2.
- gp_shift, 2, LSBs dropped before output (arithmetic right shift), 0 <= gp_shift < gp_data_width.
- gp_odata_width, 16, output width (signed), <= gp_data_width-gp_shift.
- c_cnt_width (localparam), max(1, clog2(L)), width of the phase counter.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst_an  in  1  asynchronous active-low reset
- i_ena  in  1  synchronous active-high enable; low freezes all state
- i_valid  in  1  one-cycle strobe, i_data vector valid
- i_data  in  L*gp_data_width  phase vector, signed; phase k = bits [(k+1)*gp_data_width-1 -: gp_data_width]
- i_clr  in  1  synchronous clear of o_overrun
- o_data  out  gp_odata_width  serialized sample, signed, registered
- o_valid  out  1  o_data valid (registered flag AND i_ena)
- o_phase  out  c_cnt_width  phase index of current o_data, registered
- o_overrun  out  1  sticky overrun flag

Behaviour:
- Reset (async, i_rst_an=0): state=IDLE, cnt=0, hold=0, o_data=0, o_valid flag=0, o_phase=0, o_overrun=0. Takes effect immediately mid-burst; the remainder of the burst is discarded.
- i_ena=0: every register holds, i_valid and i_clr ignored, o_valid=0. Registered flag is kept, so the burst resumes where it stopped.
- States: IDLE, RUN.
  - IDLE & i_valid: hold<=i_data, cnt<=0, ->RUN.
  - RUN, each enabled edge:
    - o_data <= sat(scale(hold[cnt])); o_phase<=cnt; o_valid flag<=1.
    - cnt==L-1 & !i_valid: ->IDLE, cnt<=0.
    - cnt==L-1 & i_valid: reload hold, cnt<=0, stay RUN (seamless, no gap).
    - cnt<L-1 & !i_valid: cnt<=cnt+1.
    - cnt<L-1 & i_valid: overrun. o_overrun<=1, reload hold, cnt<=0. Current edge still emits hold[cnt] from the old vector.
  - IDLE edge: o_valid flag<=0; o_data and o_phase hold their last values.
- Latency: i_valid in cycle t, phase k visible in cycle t+2+k; o_valid high for t+2..t+L+1.
- i_valid every L cycles gives continuous o_valid.
- scale(x) = x >>> gp_shift (arithmetic), computed at gp_data_width+1 bits to absorb the rounding carry.
- sat: if the scaled value is above 2^(OW-1)-1, output 2^(OW-1)-1; if below -2^(OW-1), output -2^(OW-1).
- o_overrun: set has priority over i_clr in the same cycle; otherwise cleared by i_clr.
- Expected implementation size: ~150-250 RTL lines.

Optional Feature:
- Macro: PPI_COMMUTATOR_ROUND_EN.
- Defined: round half-up before the shift, scale(x) = (x + 2^(gp_shift-1)) >>> gp_shift. This applies only when gp_shift>0; the rounding carry is then saturated.
- Undefined: plain truncation, scale(x) = x >>> gp_shift.
- All other behaviour is identical.

Test Plan (L=4, W=20, shift=2, OW=16):
- Single burst: i_valid at cycle 10, phases {0x00004,0x00008,0x0000C,0x00010} -> cycles 12..15 give o_data 1,2,3,4, o_phase 0..3, o_valid=1; cycle 16 o_valid=0 and o_data stays 4.
- Saturation: phase0=0x7FFFF, phase1=0x80000 -> o_data 0x7FFF then 0x8000.
- Rounding: phase0=6, phase1=-6 -> with macro 2, -1; without macro 1, -2.
- Back-to-back and overrun:
  - i_valid every 4 cycles for 3 vectors -> 12 consecutive o_valid, o_overrun=0.
  - Then i_valid 2 cycles after the previous one -> o_overrun=1, o_phase restarts at 0 on the next output.
  - i_clr -> o_overrun=0.
- Enable freeze: i_ena=0 for 3 cycles after phase 1 is emitted -> o_valid=0 and o_data/o_phase stable; on re-enable phases 2,3 follow with no loss.
- Reset mid-burst: i_rst_an low during phase 2 -> o_data=0, o_valid=0, o_phase=0 immediately; after release, no output until the next i_valid.
